mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one unified 32-bit big-endian memory port between instruction fetch (IF) and the data memory stage (M).
- Drives a variable-latency Req/Ack handshake, generates byte enables and write-lane replication for byte/half/word stores, and sign/zero-extends load data.
- Holds each served result until the pipeline advances, and produces per-port stall signals for the hazard unit.

Parameters:
- ADDR_WIDTH, 30: word-address width of Mem_Addr; the byte address is {Mem_Addr, 2'b00}.
- DATA_FIRST, 1: 1 = data port wins when both are pending; 0 = instruction port wins.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- Advance  in  1  pipeline advances this cycle (hazard unit: no stall anywhere)
- IF_Req  in  1  fetch requested
- IF_Addr  in  32  fetch byte address (word aligned)
- IF_Inst  out  32  fetched instruction (registered)
- IF_Stall  out  1  IF_Req & ~IF_Done
- M_Read, M_Write  in  1 each  load / store request (CtlBus MemRead/MemWrite)
- M_Byte, M_Half, M_SignExt  in  1 each  access size and load extension
- M_Addr  in  32  data byte address
- M_WData  in  32  store data (value in low bits)
- M_RData  out  32  extended load result (registered)
- M_Stall  out  1  (M_Read|M_Write) & ~M_Done & ~M_Unaligned
- M_Unaligned  out  1  combinational: half with Addr[0]=1, or word with Addr[1:0]!=0
- Mem_Req  out  1  access request
- Mem_Wr  out  1  1 = write
- Mem_Addr  out  ADDR_WIDTH  word address
- Mem_BE  out  4  byte enables; BE[3] = bits 31:24 = byte offset 0
- Mem_WData  out  32  lane-replicated write data
- Mem_RData  in  32  read data, valid when Mem_Ack=1
- Mem_Ack  in  1  access complete (single-cycle pulse)

Behaviour:
- Reset (async, while reset_n=0): state IDLE; Mem_Req, Mem_Wr = 0; Mem_Addr, Mem_BE, Mem_WData = 0; IF_Inst, M_RData = 0; IF_Done, M_Done = 0.
- FSM states: IDLE, INST, DATA.
  - IDLE: pendD = (M_Read|M_Write) & ~M_Done & ~M_Unaligned; pendI = IF_Req & ~IF_Done. Pick per DATA_FIRST. Next edge: register address/BE/wdata, Mem_Req=1, go to INST or DATA.
  - INST/DATA: Mem_* held stable until the Mem_Ack cycle.
  - On ack: Mem_Req=0, capture result, set Done, return to IDLE.
  - No preemption of an in-flight access. Minimum latency: request issued 1 cycle after the stall is seen; result visible the cycle after Mem_Ack.
- Done flags: set on ack, cleared on any cycle with Advance=1. Advance has priority over a same-cycle set only if the state is IDLE (it cannot coincide otherwise). A port with Done=1 is never re-served.
- Size encoding:
  - word: BE=1111.
  - half: BE = Addr[1] ? 0011 : 1100; WData = {2{WData[15:0]}}.
  - byte: BE = 1000 >> Addr[1:0]; WData = {4{WData[7:0]}}.
  - Fetches are word reads.
- Load extraction uses the address and size registered at issue: select the lane, then extend per M_SignExt. Word loads pass through.
- Unaligned: no memory access, M_Stall=0. Signalling is the hazard unit's job; M_RData is unchanged.
- Mem_Ack in IDLE is ignored.
- Reset mid-access abandons the request; the memory must tolerate a dropped Req.
- M_Read and M_Write both high: treat as a write.

Decomposition:
- cpu_para.v gains: FSM state codes (2-bit), BE constants (BE_WORD, BE_HALF_HI/LO, BE_BYTE0), and MEMADDR_WIDTH.
- One sub-module: mem_lane_align. It is combinational and holds BE generation, write replication, and load extract/extend. It is instantiated once and shared by the issue and capture paths.

Test Plan:
- IF_Req=1, IF_Addr=0x00400010, Mem_Ack 3 cycles after Req → Mem_Addr=0x00100004, BE=1111; IF_Stall high 4 cycles; IF_Inst=Mem_RData; stall low until Advance.
- IF and load word at 0x100 requested together, DATA_FIRST=1 → data served first; IF served only after the data ack; both stalls low before Advance clears both Done flags.
- Store byte 0xAB at 0x203 → BE=0001, WData=0xABABABAB, Mem_Wr=1. Store half 0x1234 at 0x202 → BE=0011, WData=0x12341234.
- Load byte at offset 1 of 0x80FF0000: with SignExt → 0xFFFFFFFF; without SignExt → 0x000000FF. Lhu at offset 0 of 0x8001xxxx → 0x00008001.
- Lw at 0x102 → M_Unaligned=1, M_Stall=0, no Mem_Req.
- reset_n pulsed low while in DATA → Mem_Req=0 immediately; FSM in IDLE; Done flags clear; a late Mem_Ack is ignored.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory-port arbiter.
//   - arbiter FSM state codes
//   - access size encoding used by the lane aligner
//   - byte-enable constants (BE[3] = bits 31:24 = byte offset 0, big-endian)
//   - default word-address width of the memory port
package mem_port_arbiter_pkg;

  localparam int MEMADDR_WIDTH = 30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INST = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } acc_size_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_BYTE0   = 4'b1000;

  // Byte wins over half if both strobes are set; neither means word.
  function automatic acc_size_e size_of(input logic is_byte, input logic is_half);
    if (is_byte) return SZ_BYTE;
    if (is_half) return SZ_HALF;
    return SZ_WORD;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-side Req/Ack bus of the arbiter.
//   master (arbiter): drives Mem_Req, Mem_Wr, Mem_Addr (word address),
//                     Mem_BE, Mem_WData; receives Mem_RData, Mem_Ack.
//   slave  (memory) : the mirror image.
// Mem_Ack is a single-cycle pulse; Mem_RData is valid in that cycle.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 30
);
  logic                  Mem_Req;
  logic                  Mem_Wr;
  logic [ADDR_WIDTH-1:0] Mem_Addr;
  logic [3:0]            Mem_BE;
  logic [31:0]           Mem_WData;
  logic [31:0]           Mem_RData;
  logic                  Mem_Ack;

  modport master (
    output Mem_Req, Mem_Wr, Mem_Addr, Mem_BE, Mem_WData,
    input  Mem_RData, Mem_Ack
  );

  modport slave (
    input  Mem_Req, Mem_Wr, Mem_Addr, Mem_BE, Mem_WData,
    output Mem_RData, Mem_Ack
  );
endinterface

// File: rtl/mem_port_arbiter_lane_align.sv
// mem_lane_align: purely combinational big-endian lane logic.
//   size, offset    : access size and byte offset within the word
//   sign_ext        : sign-extend (1) or zero-extend (0) sub-word loads
//   store_data      : store value, right-justified
//   load_word       : raw 32-bit word from memory
//   be              : byte enables (BE[3] = byte offset 0)
//   store_lanes     : store value replicated across all lanes
//   load_data       : selected and extended load value
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  acc_size_e   size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] store_lanes,
  output logic [31:0] load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Big-endian: offset 0 is the most significant byte.
  always_comb begin
    byte_v = load_word[31:24];
    case (offset)
      2'd1:    byte_v = load_word[23:16];
      2'd2:    byte_v = load_word[15:8];
      2'd3:    byte_v = load_word[7:0];
      default: byte_v = load_word[31:24];
    endcase
  end

  assign half_v = offset[1] ? load_word[15:0] : load_word[31:16];

  always_comb begin
    be          = BE_WORD;
    store_lanes = store_data;
    load_data   = load_word;
    case (size)
      SZ_HALF: begin
        be          = offset[1] ? BE_HALF_LO : BE_HALF_HI;
        store_lanes = {2{store_data[15:0]}};
        load_data   = {{16{sign_ext & half_v[15]}}, half_v};
      end
      SZ_BYTE: begin
        be          = BE_BYTE0 >> offset;
        store_lanes = {4{store_data[7:0]}};
        load_data   = {{24{sign_ext & byte_v[7]}}, byte_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 32-bit big-endian memory port between
// instruction fetch (IF) and the data memory stage (M).
//   clock, reset_n      : rising-edge clock, async active-low reset
//   Advance             : pipeline advances; clears both Done flags
//   IF_Req/IF_Addr      : fetch request and byte address
//   IF_Inst/IF_Stall    : registered instruction, fetch stall
//   M_Read/M_Write      : load/store request (both high = store)
//   M_Byte/M_Half/M_SignExt, M_Addr, M_WData : data access description
//   M_RData/M_Stall     : registered extended load result, data stall
//   M_Unaligned         : combinational misalignment flag
//   mem                 : memory Req/Ack bus (master side)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = MEMADDR_WIDTH,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        Advance,
  input  logic        IF_Req,
  input  logic [31:0] IF_Addr,
  output logic [31:0] IF_Inst,
  output logic        IF_Stall,
  input  logic        M_Read,
  input  logic        M_Write,
  input  logic        M_Byte,
  input  logic        M_Half,
  input  logic        M_SignExt,
  input  logic [31:0] M_Addr,
  input  logic [31:0] M_WData,
  output logic [31:0] M_RData,
  output logic        M_Stall,
  output logic        M_Unaligned,
  mem_port_arbiter_if.master mem
);

  arb_state_e state_reg;
  logic       if_done_reg;
  logic       m_done_reg;
  acc_size_e  size_reg;
  logic [1:0] off_reg;
  logic       sext_reg;

  acc_size_e  m_size;
  acc_size_e  size_sel;
  logic [1:0] off_sel;
  logic       pend_d, pend_i, pick_d, pick_i;
  logic [3:0] la_be;
  logic [31:0] la_wdata, la_rdata;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^IF_Addr[1:0];

  assign m_size      = size_of(M_Byte, M_Half);
  assign M_Unaligned = ((m_size == SZ_HALF) && M_Addr[0]) ||
                       ((m_size == SZ_WORD) && (M_Addr[1:0] != 2'b00));

  assign pend_d = (M_Read | M_Write) & ~m_done_reg & ~M_Unaligned;
  assign pend_i = IF_Req & ~if_done_reg;
  assign pick_d = pend_d & (DATA_FIRST | ~pend_i);
  assign pick_i = pend_i & ~pick_d;

  assign IF_Stall = IF_Req & ~if_done_reg;
  assign M_Stall  = (M_Read | M_Write) & ~m_done_reg & ~M_Unaligned;

  // One aligner serves both paths: while idle it sees the live request
  // (BE / lane replication for issue); while busy it sees the size and
  // offset latched at issue (load extraction at capture).
  assign size_sel = (state_reg == ST_IDLE) ? m_size : size_reg;
  assign off_sel  = (state_reg == ST_IDLE) ? M_Addr[1:0] : off_reg;

  mem_lane_align u_align (
    .size        (size_sel),
    .offset      (off_sel),
    .sign_ext    (sext_reg),
    .store_data  (M_WData),
    .load_word   (mem.Mem_RData),
    .be          (la_be),
    .store_lanes (la_wdata),
    .load_data   (la_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      if_done_reg   <= 1'b0;
      m_done_reg    <= 1'b0;
      size_reg      <= SZ_WORD;
      off_reg       <= 2'b00;
      sext_reg      <= 1'b0;
      IF_Inst       <= '0;
      M_RData       <= '0;
      mem.Mem_Req   <= 1'b0;
      mem.Mem_Wr    <= 1'b0;
      mem.Mem_Addr  <= '0;
      mem.Mem_BE    <= '0;
      mem.Mem_WData <= '0;
    end else begin
      // A Done set can only happen on an ack (never in IDLE), so letting
      // the set win gives Advance priority exactly when the FSM is idle.
      if (state_reg == ST_INST && mem.Mem_Ack) if_done_reg <= 1'b1;
      else if (Advance)                        if_done_reg <= 1'b0;
      if (state_reg == ST_DATA && mem.Mem_Ack) m_done_reg <= 1'b1;
      else if (Advance)                        m_done_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (pick_d) begin
            mem.Mem_Req   <= 1'b1;
            mem.Mem_Wr    <= M_Write;
            mem.Mem_Addr  <= M_Addr[ADDR_WIDTH+1:2];
            mem.Mem_BE    <= la_be;
            mem.Mem_WData <= la_wdata;
            size_reg      <= m_size;
            off_reg       <= M_Addr[1:0];
            sext_reg      <= M_SignExt;
            state_reg     <= ST_DATA;
          end else if (pick_i) begin
            mem.Mem_Req   <= 1'b1;
            mem.Mem_Wr    <= 1'b0;
            mem.Mem_Addr  <= IF_Addr[ADDR_WIDTH+1:2];
            mem.Mem_BE    <= BE_WORD;
            state_reg     <= ST_INST;
          end
        end
        ST_INST: begin
          if (mem.Mem_Ack) begin
            mem.Mem_Req <= 1'b0;
            IF_Inst     <= mem.Mem_RData;
            state_reg   <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (mem.Mem_Ack) begin
            mem.Mem_Req <= 1'b0;
            mem.Mem_Wr  <= 1'b0;
            if (!mem.Mem_Wr) M_RData <= la_rdata;
            state_reg   <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
